// File: rtl/mem_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// mem_ctrl_pkg
// Shared definitions for the memory-stage controller:
//   - default parameter widths (data, address, REQ timeout)
//   - op-code constants for the three memory-stage instructions
//   - FSM state encoding
//   - small decode helper used by the controller
// -----------------------------------------------------------------------------
package mem_ctrl_pkg;

  localparam int DEF_DATA_W  = 32;
  localparam int DEF_ADDR_W  = 32;
  localparam int DEF_TIMEOUT = 15;

  // Any op code other than these three is an ALU pass-through.
  localparam logic [3:0] OP_ADR = 4'b1100;
  localparam logic [3:0] OP_LDR = 4'b1101;
  localparam logic [3:0] OP_STR = 4'b1110;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } state_t;

  // True for the two op codes that run a RAM transaction.
  function automatic logic is_mem_op(input logic [3:0] op);
    return (op == OP_LDR) || (op == OP_STR);
  endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// -----------------------------------------------------------------------------
// mem_access_unit_if
// Bundles the execute-stage inputs, the register-writeback outputs and the
// RAM req/ack bus of mem_access_unit.
//   CPU side : start, op_code, SR1, SR2, offset, ALU_result -> unit
//              busy, reg_data, reg_we                       <- unit
//   RAM side : RAM_out, ram_ack                             -> unit
//              address_out, RW, RAM_in, ram_req             <- unit
//   status   : fault                                        <- unit
// Modports:
//   slave  - the controller (mem_access_unit)
//   master - whatever drives the controller (CPU pipeline + RAM)
// -----------------------------------------------------------------------------
interface mem_access_unit_if
  import mem_ctrl_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) ();

  // Execute stage -> memory stage
  logic              start;
  logic [3:0]        op_code;
  logic [DATA_W-1:0] SR1;
  logic [DATA_W-1:0] SR2;
  logic [ADDR_W-1:0] offset;
  logic [DATA_W-1:0] ALU_result;

  // RAM -> memory stage
  logic [DATA_W-1:0] RAM_out;
  logic              ram_ack;

  // Memory stage -> CPU
  logic              busy;
  logic [DATA_W-1:0] reg_data;
  logic              reg_we;
  logic              fault;

  // Memory stage -> RAM
  logic [ADDR_W-1:0] address_out;
  logic              RW;
  logic [DATA_W-1:0] RAM_in;
  logic              ram_req;

  modport slave (
    input  start, op_code, SR1, SR2, offset, ALU_result, RAM_out, ram_ack,
    output busy, reg_data, reg_we, fault, address_out, RW, RAM_in, ram_req
  );

  modport master (
    output start, op_code, SR1, SR2, offset, ALU_result, RAM_out, ram_ack,
    input  busy, reg_data, reg_we, fault, address_out, RW, RAM_in, ram_req
  );

endinterface

// File: rtl/addr_gen.sv
// -----------------------------------------------------------------------------
// addr_gen
// Combinational base + offset adder producing an ADDR_W-bit address that wraps
// modulo 2^ADDR_W. One instance feeds both the ADR writeback path and the
// LDR/STR address register.
// Ports:
//   i_base   in  ADDR_W  base (low ADDR_W bits of SR1)
//   i_offset in  ADDR_W  unsigned offset
//   o_sum    out ADDR_W  (i_base + i_offset) mod 2^ADDR_W
// -----------------------------------------------------------------------------
module addr_gen
  import mem_ctrl_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic [ADDR_W-1:0] i_base,
  input  logic [ADDR_W-1:0] i_offset,
  output logic [ADDR_W-1:0] o_sum
);

  // Result is sized to ADDR_W, so the carry out is dropped and the sum wraps.
  assign o_sum = i_base + i_offset;

endmodule

// File: rtl/mem_access_unit.sv
// -----------------------------------------------------------------------------
// mem_access_unit
// Memory-stage controller between the execute stage and the data RAM.
//   - ALU ops : ALU_result is written back one cycle after start.
//   - ADR     : SR1 + offset (wrapping) is written back one cycle after start.
//   - LDR/STR : address/RW/RAM_in are registered and a req/ack transaction is
//               run; busy stalls the CPU while the request is outstanding.
//               LDR writes RAM_out back the cycle after ram_ack. A request
//               that sees no ack for TIMEOUT+1 cycles is dropped with a
//               one-cycle fault pulse.
// All outputs come straight from registers.
// Ports:
//   clk    in  system clock, rising-edge
//   Reset  in  synchronous active-high reset
//   bus    mem_access_unit_if.slave (CPU, RAM and status signals)
// Assumes DATA_W >= ADDR_W (the address is taken from SR1's low bits and
// zero-extended for ADR writeback).
// -----------------------------------------------------------------------------
module mem_access_unit
  import mem_ctrl_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic             clk,
  input  logic             Reset,
  mem_access_unit_if.slave bus
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);

  // State and output registers
  state_t            r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_busy;
  logic [DATA_W-1:0] r_reg_data;
  logic              r_reg_we;
  logic [ADDR_W-1:0] r_address_out;
  logic              r_rw;
  logic [DATA_W-1:0] r_ram_in;
  logic              r_ram_req;
  logic              r_fault;

  // Next-state values
  state_t            w_next_state;
  logic [CNT_W-1:0]  w_cnt_nxt;
  logic              w_busy_nxt;
  logic [DATA_W-1:0] w_reg_data_nxt;
  logic              w_reg_we_nxt;
  logic [ADDR_W-1:0] w_address_nxt;
  logic              w_rw_nxt;
  logic [DATA_W-1:0] w_ram_in_nxt;
  logic              w_ram_req_nxt;
  logic              w_fault_nxt;

  // Shared base + offset address
  logic [ADDR_W-1:0] w_addr_sum;
  logic [DATA_W-1:0] w_addr_ext;

  addr_gen #(
    .ADDR_W (ADDR_W)
  ) u_addr_gen (
    .i_base   (bus.SR1[ADDR_W-1:0]),
    .i_offset (bus.offset),
    .o_sum    (w_addr_sum)
  );

  assign w_addr_ext = DATA_W'(w_addr_sum);

  // ---------------------------------------------------------------------------
  // Next-state / next-output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves
    // one unassigned; that is what keeps this block free of inferred latches.
    w_next_state   = r_state;
    w_cnt_nxt      = r_cnt;
    w_busy_nxt     = r_busy;
    w_reg_data_nxt = r_reg_data;
    w_reg_we_nxt   = 1'b0;
    w_address_nxt  = r_address_out;
    w_rw_nxt       = r_rw;
    w_ram_in_nxt   = r_ram_in;
    w_ram_req_nxt  = r_ram_req;
    w_fault_nxt    = 1'b0;

    case (r_state)
      // IDLE and DONE both accept a new instruction; DONE only differs in
      // that the previous writeback strobe is visible during it.
      IDLE, DONE: begin
        w_next_state = IDLE;
        if (bus.start) begin
          if (is_mem_op(bus.op_code)) begin
            w_address_nxt = w_addr_sum;
            w_rw_nxt      = (bus.op_code == OP_LDR);
            // A load leaves RAM_in at whatever the last store drove.
            if (bus.op_code == OP_STR) begin
              w_ram_in_nxt = bus.SR2;
            end
            w_cnt_nxt     = '0;
            w_ram_req_nxt = 1'b1;
            w_busy_nxt    = 1'b1;
            w_next_state  = REQ;
          end else if (bus.op_code == OP_ADR) begin
            w_reg_data_nxt = w_addr_ext;
            w_reg_we_nxt   = 1'b1;
            w_next_state   = DONE;
          end else begin
            w_reg_data_nxt = bus.ALU_result;
            w_reg_we_nxt   = 1'b1;
            w_next_state   = DONE;
          end
        end
      end

      // start is ignored here: busy is high and the CPU holds.
      REQ: begin
        if (bus.ram_ack) begin
          // Checked before the timeout so an ack on the last cycle still wins.
          w_ram_req_nxt = 1'b0;
          w_busy_nxt    = 1'b0;
          w_next_state  = DONE;
          if (r_rw) begin
            w_reg_data_nxt = bus.RAM_out;
            w_reg_we_nxt   = 1'b1;
          end
        end else if (r_cnt == CNT_MAX) begin
          w_ram_req_nxt = 1'b0;
          w_busy_nxt    = 1'b0;
          w_fault_nxt   = 1'b1;
          w_next_state  = IDLE;
        end else begin
          // Only reached below CNT_MAX, so the counter saturates, never wraps.
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end

      default: begin
        w_next_state  = IDLE;
        w_ram_req_nxt = 1'b0;
        w_busy_nxt    = 1'b0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State and output registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples the pre-edge
    // values computed above, independent of statement order.
    if (Reset) begin
      r_state       <= IDLE;
      r_cnt         <= '0;
      r_busy        <= 1'b0;
      r_reg_data    <= '0;
      r_reg_we      <= 1'b0;
      r_address_out <= '0;
      r_rw          <= 1'b0;
      r_ram_in      <= '0;
      r_ram_req     <= 1'b0;
      r_fault       <= 1'b0;
    end else begin
      r_state       <= w_next_state;
      r_cnt         <= w_cnt_nxt;
      r_busy        <= w_busy_nxt;
      r_reg_data    <= w_reg_data_nxt;
      r_reg_we      <= w_reg_we_nxt;
      r_address_out <= w_address_nxt;
      r_rw          <= w_rw_nxt;
      r_ram_in      <= w_ram_in_nxt;
      r_ram_req     <= w_ram_req_nxt;
      r_fault       <= w_fault_nxt;
    end
  end

  assign bus.busy        = r_busy;
  assign bus.reg_data    = r_reg_data;
  assign bus.reg_we      = r_reg_we;
  assign bus.address_out = r_address_out;
  assign bus.RW          = r_rw;
  assign bus.RAM_in      = r_ram_in;
  assign bus.ram_req     = r_ram_req;
  assign bus.fault       = r_fault;

endmodule

// File: tb/tb_mem_access_unit.sv
// -----------------------------------------------------------------------------
// tb_mem_access_unit
// Directed scenarios followed by random instruction traffic. The driver pushes
// expected writebacks and RAM transactions into queues; a monitor sampling on
// the falling edge pops and compares them as the DUT produces them. A RAM
// responder acks after a planned number of request cycles (or never), and
// raises stray acks whenever no request is outstanding.
// -----------------------------------------------------------------------------
module tb_mem_access_unit;
  import mem_ctrl_pkg::*;

  localparam int DATA_W  = 32;
  localparam int ADDR_W  = 32;
  localparam int TIMEOUT = 15;

  logic clk = 1'b0;
  logic Reset;

  always #5 clk = ~clk;

  mem_access_unit_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  mem_access_unit #(
    .DATA_W  (DATA_W),
    .ADDR_W  (ADDR_W),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk   (clk),
    .Reset (Reset),
    .bus   (bus)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard state
  // ---------------------------------------------------------------------------
  typedef struct {
    logic [31:0] data;
    int          due;     // cycle in which reg_we must be seen (ALU/ADR)
    bit          is_ldr;  // LDR writeback: must coincide with end of request
  } wb_exp_t;

  typedef struct {
    logic [31:0] addr;
    bit          rw;
    logic [31:0] ram_in;
    int          len;     // expected number of ram_req cycles
    bit          timeout; // request ends with a fault pulse
  } req_exp_t;

  wb_exp_t  wb_q[$];
  req_exp_t req_q[$];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  logic [31:0] model_ram_in;   // RAM_in as the model expects it
  int          plan_k    = 0;  // ack on this request cycle, 0 = never
  logic [31:0] plan_data = '0;
  bit          stray_force = 1'b0;
  bit          mon_en      = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1, "watchdog expired");
  end

  // ---------------------------------------------------------------------------
  // RAM responder
  // ---------------------------------------------------------------------------
  initial begin
    int n;
    n = 0;
    bus.ram_ack = 1'b0;
    bus.RAM_out = '0;
    forever begin
      @(negedge clk);
      if (bus.ram_req === 1'b1) begin
        n++;
        bus.ram_ack = (plan_k != 0) && (n == plan_k);
        bus.RAM_out = bus.ram_ack ? plan_data : $urandom;
      end else begin
        n = 0;
        bus.ram_ack = stray_force ? 1'b1 : ($urandom_range(0, 1) == 1);
        bus.RAM_out = $urandom;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Monitor
  // ---------------------------------------------------------------------------
  bit       m_prev_req = 1'b0;
  bit       m_rise, m_fall;
  int       m_len = 0;
  req_exp_t m_cur = '{addr: '0, rw: 1'b0, ram_in: '0, len: 0, timeout: 1'b0};
  wb_exp_t  m_wb;

  initial begin
    wait (mon_en);
    forever begin
      @(negedge clk);
      m_rise = (bus.ram_req === 1'b1) && !m_prev_req;
      m_fall = m_prev_req && (bus.ram_req !== 1'b1);

      if (m_rise) begin
        if (req_q.size() == 0) begin
          check("req_unexpected", 1, 0);
          m_cur = '{addr: '0, rw: 1'b0, ram_in: '0, len: 0, timeout: 1'b0};
        end else begin
          m_cur = req_q.pop_front();
        end
        m_len = 0;
      end

      if (bus.ram_req === 1'b1) begin
        m_len++;
        check("req_address", bus.address_out, m_cur.addr);
        check("req_rw", bus.RW, m_cur.rw);
        check("req_ram_in", bus.RAM_in, m_cur.ram_in);
      end

      if (m_fall) begin
        check("req_length", m_len, m_cur.len);
        check("fault_on_exit", bus.fault, m_cur.timeout);
      end else begin
        check("fault_spurious", bus.fault, 0);
      end

      check("busy_vs_req", bus.busy, bus.ram_req);

      if (bus.reg_we === 1'b1) begin
        if (wb_q.size() == 0) begin
          check("reg_we_unexpected", 1, 0);
        end else begin
          m_wb = wb_q.pop_front();
          check("reg_data", bus.reg_data, m_wb.data);
          if (m_wb.is_ldr) check("ldr_wb_timing", m_fall, 1);
          else             check("wb_latency_cycle", cyc, m_wb.due);
        end
      end

      m_prev_req = (bus.ram_req === 1'b1);
    end
  end

  // ---------------------------------------------------------------------------
  // Driver helpers (called at posedge + #1)
  // ---------------------------------------------------------------------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"}, bus.busy, 0);
    check({tag, "_reg_we"}, bus.reg_we, 0);
    check({tag, "_ram_req"}, bus.ram_req, 0);
    check({tag, "_fault"}, bus.fault, 0);
    check({tag, "_rw"}, bus.RW, 0);
    check({tag, "_reg_data"}, bus.reg_data, 0);
    check({tag, "_address_out"}, bus.address_out, 0);
    check({tag, "_ram_in"}, bus.RAM_in, 0);
  endtask

  // Issue one instruction; for LDR/STR wait (bounded) until busy drops,
  // presenting random starts meanwhile that the DUT must ignore.
  task automatic issue(input logic [3:0] op, input logic [31:0] sr1, input logic [31:0] sr2,
                       input logic [31:0] off, input logic [31:0] alu, input int k,
                       input logic [31:0] data);
    req_exp_t    r;
    wb_exp_t     w;
    logic [31:0] sum;
    int          budget;
    bit          mem;
    sum = sr1 + off;
    mem = (op == OP_LDR) || (op == OP_STR);
    bus.start      = 1'b1;
    bus.op_code    = op;
    bus.SR1        = sr1;
    bus.SR2        = sr2;
    bus.offset     = off;
    bus.ALU_result = alu;
    plan_k         = k;
    plan_data      = data;
    if (mem) begin
      if (op == OP_STR) model_ram_in = sr2;
      r.addr    = sum;
      r.rw      = (op == OP_LDR);
      r.ram_in  = model_ram_in;
      r.len     = (k == 0) ? TIMEOUT + 1 : k;
      r.timeout = (k == 0);
      req_q.push_back(r);
      if (op == OP_LDR && k != 0) begin
        w.data = data; w.due = 0; w.is_ldr = 1'b1;
        wb_q.push_back(w);
      end
    end else begin
      w.data   = (op == OP_ADR) ? sum : alu;
      w.due    = cyc + 1;
      w.is_ldr = 1'b0;
      wb_q.push_back(w);
    end
    step();
    if (mem) begin
      budget = 0;
      while (bus.busy === 1'b1 && budget < 100) begin
        bus.start      = ($urandom_range(0, 1) == 1);
        bus.op_code    = 4'($urandom);
        bus.SR1        = $urandom;
        bus.SR2        = $urandom;
        bus.offset     = $urandom;
        bus.ALU_result = $urandom;
        step();
        budget++;
      end
      if (budget >= 100) check("busy_release_bound", 1, 0);
    end
    bus.start = 1'b0;
  endtask

  function automatic logic [3:0] rand_alu_op();
    int o;
    o = $urandom_range(0, 12);
    return (o == 12) ? 4'hF : 4'(o);
  endfunction

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    Reset          = 1'b1;
    bus.start      = 1'b0;
    bus.op_code    = '0;
    bus.SR1        = '0;
    bus.SR2        = '0;
    bus.offset     = '0;
    bus.ALU_result = '0;
    model_ram_in   = '0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    Reset  = 1'b0;
    mon_en = 1'b1;
    step();

    // ALU back-to-back
    issue(4'h0, '0, '0, '0, 32'h11, 0, '0);
    issue(4'h3, '0, '0, '0, 32'h22, 0, '0);
    issue(4'hF, '0, '0, '0, 32'h33, 0, '0);

    // ADR wrap-around
    issue(OP_ADR, 32'hFFFF_FFF0, '0, 32'h20, '0, 0, '0);

    // LDR, ack on 4th request cycle
    issue(OP_LDR, 32'h100, 32'h5555_AAAA, 32'h4, '0, 4, 32'hDEAD_BEEF);

    // STR timeout, then a start must be accepted again
    issue(OP_STR, 32'h2000, 32'hCAFE_F00D, 32'h10, '0, 0, '0);
    issue(4'h1, '0, '0, '0, 32'h4444_0001, 0, '0);

    // Ack on the timeout cycle wins (random starts during REQ are ignored)
    issue(OP_LDR, 32'h3000, '0, 32'h8, '0, TIMEOUT + 1, 32'h0BAD_F00D);
    issue(OP_STR, 32'h3100, 32'h1234_5678, 32'h0, '0, TIMEOUT + 1, '0);

    // Reset during a pending LDR after 3 request cycles
    bus.start   = 1'b1;
    bus.op_code = OP_LDR;
    bus.SR1     = 32'h400;
    bus.offset  = 32'h0C;
    plan_k      = 0;
    req_q.push_back('{addr: 32'h40C, rw: 1'b1, ram_in: model_ram_in, len: 3, timeout: 1'b0});
    step();
    bus.start = 1'b0;
    step();
    step();
    Reset = 1'b1;
    step();
    Reset = 1'b0;
    model_ram_in = '0;
    check_reset_outputs("abort");
    stray_force = 1'b1;
    repeat (3) step();
    check("abort_ack_reg_we", bus.reg_we, 0);
    check("abort_ack_ram_req", bus.ram_req, 0);
    check("abort_ack_busy", bus.busy, 0);
    stray_force = 1'b0;

    // Random traffic
    for (int i = 0; i < 150; i++) begin
      int sel, k;
      sel = $urandom_range(0, 3);
      k   = ($urandom_range(0, 4) == 0) ? 0 : $urandom_range(1, TIMEOUT + 1);
      case (sel)
        0:       issue(rand_alu_op(), $urandom, $urandom, $urandom, $urandom, 0, '0);
        1:       issue(OP_ADR, $urandom, $urandom, $urandom, $urandom, 0, '0);
        2:       issue(OP_LDR, $urandom, $urandom, $urandom, $urandom, k, $urandom);
        default: issue(OP_STR, $urandom, $urandom, $urandom, $urandom, k, $urandom);
      endcase
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 2)) step();
    end

    repeat (5) step();
    check("wb_queue_drained", wb_q.size(), 0);
    check("req_queue_drained", req_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Parametrised, sequential memory-stage controller that sits between the execute stage and the data RAM. It decodes the 4-bit op_code and routes ALU results to register writeback. For ADR/LDR/STR it computes a base+offset address. For LDR/STR it runs a req/ack transaction with wait states and a timeout. It stalls the CPU while a RAM access is outstanding.

## Interface
- DATA_W, 32, width of register and RAM data
- ADDR_W, 32, width of RAM address
- TIMEOUT, 15, maximum cycles spent in REQ before the access is aborted (≥1)
- clk  in  1  system clock, all state updates on rising edge
- Reset  in  1  synchronous, active-high reset
- start  in  1  instruction valid for the memory stage this cycle
- op_code  in  4  1100 ADR, 1101 LDR, 1110 STR, all others ALU pass-through
- SR1  in  DATA_W  base register
- SR2  in  DATA_W  store data
- offset  in  ADDR_W  address offset, unsigned
- ALU_result  in  DATA_W  execute-stage result
- RAM_out  in  DATA_W  RAM read data, valid when ram_ack=1
- ram_ack  in  1  RAM completes the current access
- busy  out  1  stall, high while in REQ
- reg_data  out  DATA_W  writeback value
- reg_we  out  1  one-cycle writeback strobe
- address_out  out  ADDR_W  RAM address
- RW  out  1  1 = read (LDR), 0 = write
- RAM_in  out  DATA_W  RAM write data
- ram_req  out  1  access request
- fault  out  1  one-cycle pulse when an access times out

## Operation
- States: IDLE, REQ, DONE. Reset goes to IDLE.
- Reset values: busy, reg_we, ram_req, fault, RW = 0; reg_data, address_out, RAM_in = 0; timeout counter = 0.
- A start is accepted in IDLE or DONE. It is ignored in REQ, because busy=1 and the CPU must hold.
- ALU op accepted: reg_data ← ALU_result, reg_we=1 next cycle; state → DONE.
- ADR accepted: reg_data ← (SR1[ADDR_W-1:0] + offset) mod 2^ADDR_W, zero-extended to DATA_W; reg_we=1 next cycle; state → DONE.
- LDR/STR accepted:
  - Register address_out = SR1[ADDR_W-1:0] + offset (wraps modulo 2^ADDR_W).
  - Set RW = 1 for LDR and 0 for STR.
  - RAM_in ← SR2 for STR; RAM_in holds its previous value for LDR.
  - Clear the counter and go to REQ.
- REQ: ram_req=1, busy=1, and address_out, RW and RAM_in are held stable. The counter increments each cycle ram_ack=0.
  - ram_ack=1: drop ram_req next cycle and go to DONE.
    - LDR: capture reg_data ← RAM_out and pulse reg_we.
    - STR: no reg_we.
  - ram_ack=1 in the same cycle the counter reaches TIMEOUT: the ack wins; no fault.
  - Counter = TIMEOUT with ram_ack=0: drop ram_req, pulse fault one cycle, no reg_we, go to IDLE.
- DONE: reg_we is high for exactly this cycle (when applicable). With no start, go to IDLE. With start, process the new op exactly as from IDLE.
- ram_ack while not in REQ is ignored.
- Reset in any state, including REQ: next edge forces reset values; an in-flight access is abandoned silently with no fault.

## Timing
- ALU/ADR latency: 1 cycle, start at edge N, reg_we at N+1. Back-to-back throughput is 1 per cycle.
- LDR latency: ack cycle k ≥ 1 after REQ entry; reg_we and reg_data are valid one cycle after the ack.
- Minimum LDR/STR occupancy: REQ 1 cycle (ack on first REQ cycle) plus DONE 1 cycle.
- Timeout: ram_req is high for exactly TIMEOUT+1 cycles. fault asserts the cycle after the last REQ cycle, coincident with IDLE.
- Counter width is $clog2(TIMEOUT+1). It saturates at TIMEOUT and never wraps.
- All outputs are registered; no combinational path exists from ram_ack or RAM_out to outputs.

## Structure
- Package mem_ctrl_pkg holds:
  - opcode constants OP_ADR=4'b1100, OP_LDR=4'b1101, OP_STR=4'b1110;
  - state enum {IDLE, REQ, DONE};
  - default widths.
- One sub-module, addr_gen: parametrised ADDR_W combinational base+offset adder with wrap-around. It is shared by the ADR and LDR/STR paths.
- The FSM, counter and output registers live in mem_access_unit.

## Test plan
- Reset mid-REQ (LDR pending, 3 cycles waited), Reset=1 one cycle → all outputs 0 next edge, state IDLE, no fault, later ack ignored.
- ALU ops back-to-back: start every cycle with ALU_result 0x11, 0x22, 0x33 → reg_we high 3 consecutive cycles with those values; busy never high.
- ADR wrap, ADDR_W=32: SR1=0xFFFFFFF0, offset=0x20 → reg_data=0x00000010, reg_we one cycle.
- LDR with 3 wait states: SR1=0x100, offset=4, ack on 4th REQ cycle with RAM_out=0xDEADBEEF → address_out=0x104, RW=1, ram_req 4 cycles, reg_data=0xDEADBEEF with reg_we next cycle.
- STR timeout, TIMEOUT=15, no ack → ram_req high 16 cycles, RW=0, RAM_in=SR2, fault single pulse, no reg_we, start accepted afterwards.
- Ack on the timeout cycle plus start while busy: the ack completes normally with no fault; a start presented during REQ is ignored with no state change.
